// File: rtl/sm4_pkg.sv
// ============================================================================
// sm4_pkg : shared constants, types and helpers for the SM4 key schedule
// Rev 1.0
// ============================================================================
`default_nettype none

package sm4_pkg;

   localparam int         NROUNDS = 32;
   localparam logic [7:0] CK_STEP = 8'd28;

   localparam logic [31:0] FK0 = 32'hA3B1BAC6;
   localparam logic [31:0] FK1 = 32'h56AA3350;
   localparam logic [31:0] FK2 = 32'h677D9197;
   localparam logic [31:0] FK3 = 32'hB27022DC;
   localparam logic [31:0] CK0 = 32'h00070E15;

   typedef logic [31:0] word_t;
   typedef logic [4:0]  round_t;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam logic [7:0] SBOX [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   // Each CK byte advances independently; no carry crosses a byte boundary.
   function automatic word_t ck_advance(input word_t ck);
      word_t r;
      for (int j = 0; j < 4; j++) begin
         r[8*j +: 8] = ck[8*j +: 8] + CK_STEP;
      end
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/sm4_key_schedule_frk.sv
// ============================================================================
// Frk_function : combinational SM4 key round, rk = K0 ^ T'(K1^K2^K3^CK)
// Rev 1.0
// ============================================================================
`default_nettype none

module Trk_synchange
   import sm4_pkg::*;
(
   input  logic [31:0] i_x,
   output logic [31:0] o_y
);

   word_t w_b;

   assign w_b = {SBOX[i_x[31:24]], SBOX[i_x[23:16]], SBOX[i_x[15:8]], SBOX[i_x[7:0]]};

   // Key-schedule linear layer L': B ^ (B <<< 13) ^ (B <<< 23)
   assign o_y = w_b ^ {w_b[18:0], w_b[31:19]} ^ {w_b[8:0], w_b[31:9]};

endmodule

module Frk_function
   import sm4_pkg::*;
(
   input  logic [31:0] i_k0,
   input  logic [31:0] i_k1,
   input  logic [31:0] i_k2,
   input  logic [31:0] i_k3,
   input  logic [31:0] i_ck,
   output logic [31:0] o_rk
);

   word_t w_t_in;
   word_t w_t_out;

   assign w_t_in = i_k1 ^ i_k2 ^ i_k3 ^ i_ck;

   Trk_synchange u_trk (
      .i_x (w_t_in),
      .o_y (w_t_out)
   );

   assign o_rk = i_k0 ^ w_t_out;

endmodule

`default_nettype wire

// File: rtl/sm4_key_schedule.sv
// ============================================================================
// sm4_key_schedule : sequential SM4 key expansion with 32-entry round-key store
// Rev 1.0
// ============================================================================
`default_nettype none

module sm4_key_schedule
   import sm4_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [0:127] mk,
   output logic         busy,
   output logic         rk_valid,
   output logic [0:31]  rk_out,
   output logic [4:0]   rk_idx,
   output logic         done,
   output logic         key_ready,
   input  logic [4:0]   rk_rd_idx,
   output logic [0:31]  rk_rd_data
);

   state_t r_state;
   state_t w_state_nxt;
   logic   w_accept;
   logic   w_last;

   word_t  r_k0;
   word_t  r_k1;
   word_t  r_k2;
   word_t  r_k3;
   word_t  r_ck;
   round_t r_round;

   word_t  r_rk_out;
   round_t r_rk_idx;
   logic   r_rk_valid;
   logic   r_done;
   logic   r_key_ready;

   word_t  r_store [NROUNDS];
   word_t  w_rk;

   Frk_function u_frk (
      .i_k0 (r_k0),
      .i_k1 (r_k1),
      .i_k2 (r_k2),
      .i_k3 (r_k3),
      .i_ck (r_ck),
      .o_rk (w_rk)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_accept    = 1'b1;
               w_state_nxt = RUN;
            end
         end
         RUN: begin
            if (r_round == round_t'(NROUNDS - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k0        <= '0;
         r_k1        <= '0;
         r_k2        <= '0;
         r_k3        <= '0;
         r_ck        <= '0;
         r_round     <= '0;
         r_rk_out    <= '0;
         r_rk_idx    <= '0;
         r_rk_valid  <= 1'b0;
         r_done      <= 1'b0;
         r_key_ready <= 1'b0;
      end else begin
         r_rk_valid <= 1'b0;
         r_done     <= 1'b0;
         if (w_accept) begin
            r_k0        <= mk[0:31]   ^ FK0;
            r_k1        <= mk[32:63]  ^ FK1;
            r_k2        <= mk[64:95]  ^ FK2;
            r_k3        <= mk[96:127] ^ FK3;
            r_ck        <= CK0;
            r_round     <= '0;
            r_key_ready <= 1'b0;
         end else if (r_state == RUN) begin
            // Sliding window: the fresh round key enters as the newest word.
            r_k0       <= r_k1;
            r_k1       <= r_k2;
            r_k2       <= r_k3;
            r_k3       <= w_rk;
            r_ck       <= ck_advance(r_ck);
            r_round    <= r_round + 5'd1;
            r_rk_out   <= w_rk;
            r_rk_idx   <= r_round;
            r_rk_valid <= 1'b1;
            if (w_last) begin
               r_done      <= 1'b1;
               r_key_ready <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NROUNDS; i++) begin
            r_store[i] <= '0;
         end
      end else if (r_state == RUN) begin
         r_store[r_round] <= w_rk;
      end
   end

   assign busy       = (r_state == RUN);
   assign rk_valid   = r_rk_valid;
   assign rk_out     = r_rk_out;
   assign rk_idx     = r_rk_idx;
   assign done       = r_done;
   assign key_ready  = r_key_ready;
   assign rk_rd_data = r_store[rk_rd_idx];

endmodule

`default_nettype wire

// File: tb/tb_sm4_key_schedule.sv
// ============================================================================
// tb_sm4_key_schedule : directed self-checking bench for sm4_key_schedule
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_sm4_key_schedule;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic [0:127] mk;
   logic         busy;
   logic         rk_valid;
   logic [0:31]  rk_out;
   logic [4:0]   rk_idx;
   logic         done;
   logic         key_ready;
   logic [4:0]   rk_rd_idx;
   logic [0:31]  rk_rd_data;

   int checks = 0;
   int errors = 0;

   logic [31:0] exp_rk  [32];
   logic [31:0] seen_rk [32];

   localparam logic [127:0] KEY1 = 128'h0123456789ABCDEFFEDCBA9876543210;

   localparam logic [7:0] SB [256] = '{
      8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
      8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
      8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
      8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
      8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
      8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
      8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
      8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
      8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
      8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
      8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
      8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
      8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
      8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
      8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
      8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
   };

   sm4_key_schedule dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .mk         (mk),
      .busy       (busy),
      .rk_valid   (rk_valid),
      .rk_out     (rk_out),
      .rk_idx     (rk_idx),
      .done       (done),
      .key_ready  (key_ready),
      .rk_rd_idx  (rk_rd_idx),
      .rk_rd_data (rk_rd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] tprime(input logic [31:0] x);
      logic [31:0] b;
      b = {SB[x[31:24]], SB[x[23:16]], SB[x[15:8]], SB[x[7:0]]};
      return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
   endfunction

   // Reference expansion straight from the algorithm definition, CK from its closed form.
   task automatic build_model(input logic [127:0] key);
      logic [31:0] k [4];
      logic [31:0] ck;
      logic [31:0] rk;
      k[0] = key[127:96] ^ 32'hA3B1BAC6;
      k[1] = key[95:64]  ^ 32'h56AA3350;
      k[2] = key[63:32]  ^ 32'h677D9197;
      k[3] = key[31:0]   ^ 32'hB27022DC;
      for (int i = 0; i < 32; i++) begin
         for (int j = 0; j < 4; j++) begin
            ck[31-8*j -: 8] = 8'((4*i + j) * 7);
         end
         rk        = k[0] ^ tprime(k[1] ^ k[2] ^ k[3] ^ ck);
         exp_rk[i] = rk;
         k[0] = k[1];
         k[1] = k[2];
         k[2] = k[3];
         k[3] = rk;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [127:0] key);
      mk    = key;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("accept_busy", 32'(busy), 32'd1);
      chk("accept_valid", 32'(rk_valid), 32'd0);
      chk("accept_key_ready", 32'(key_ready), 32'd0);
      chk("accept_done", 32'(done), 32'd0);
   endtask

   // inj: round at which an all-ones start is pulsed; abrt: round at which reset hits.
   task automatic run_loop(input int inj, input int abrt);
      logic [127:0] saved;
      saved = mk;
      for (int i = 0; i < 32; i++) begin
         if (i == abrt) begin
            rst_n     = 1'b0;
            rk_rd_idx = 5'd15;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            chk("abort_valid", 32'(rk_valid), 32'd0);
            chk("abort_rk_out", rk_out, 32'd0);
            chk("abort_rk_idx", 32'(rk_idx), 32'd0);
            chk("abort_done", 32'(done), 32'd0);
            chk("abort_key_ready", 32'(key_ready), 32'd0);
            chk("abort_store", rk_rd_data, 32'd0);
            #1;
            rst_n = 1'b1;
            return;
         end
         if (i == inj) begin
            start = 1'b1;
            mk    = '1;
         end
         tick();
         if (i == inj) begin
            start = 1'b0;
            mk    = saved;
         end
         chk($sformatf("valid_%0d", i), 32'(rk_valid), 32'd1);
         chk($sformatf("idx_%0d", i), 32'(rk_idx), 32'(i));
         chk($sformatf("rk_%0d", i), rk_out, exp_rk[i]);
         chk($sformatf("done_%0d", i), 32'(done), 32'(i == 31));
         chk($sformatf("busy_%0d", i), 32'(busy), 32'(i != 31));
         seen_rk[i] = rk_out;
         if (i == 30) chk("ck_round31", dut.r_ck, 32'h646B7279);
      end
      chk("key_ready_after_run", 32'(key_ready), 32'd1);
   endtask

   task automatic sweep(input string tag);
      for (int i = 0; i < 32; i++) begin
         rk_rd_idx = 5'(i);
         #1;
         chk($sformatf("%s_%0d", tag, i), rk_rd_data, exp_rk[i]);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      start     = 1'b0;
      mk        = '0;
      rk_rd_idx = 5'd0;
      #12;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(rk_valid), 32'd0);
      chk("rst_rk_out", rk_out, 32'd0);
      chk("rst_rk_idx", 32'(rk_idx), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_key_ready", 32'(key_ready), 32'd0);
      chk("rst_store", rk_rd_data, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("idle_busy", 32'(busy), 32'd0);

      // Scenario 1: standard vector
      build_model(KEY1);
      do_start(KEY1);
      run_loop(-1, -1);
      chk("vec_rk0", seen_rk[0], 32'hF12186F9);
      chk("vec_rk1", seen_rk[1], 32'h41662B61);
      chk("vec_rk31", seen_rk[31], 32'h9124A012);
      tick();
      chk("post_valid", 32'(rk_valid), 32'd0);
      chk("post_done", 32'(done), 32'd0);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_key_ready", 32'(key_ready), 32'd1);

      // Store readback versus streamed keys
      for (int i = 0; i < 32; i++) begin
         rk_rd_idx = 5'(i);
         #1;
         chk($sformatf("rd_stream_%0d", i), rk_rd_data, seen_rk[i]);
      end
      chk("rd_idx31", rk_rd_data, 32'h9124A012);
      tick();

      // Start during RUN is ignored
      do_start(KEY1);
      run_loop(10, -1);
      tick();

      // Reset mid-run, then a fresh run
      do_start(KEY1);
      run_loop(-1, 15);
      tick();
      chk("post_abort_busy", 32'(busy), 32'd0);
      do_start(KEY1);
      run_loop(-1, -1);

      // Back-to-back: zero key straight after done, then KEY1
      build_model(128'h0);
      do_start(128'h0);
      run_loop(-1, -1);
      build_model(KEY1);
      do_start(KEY1);
      run_loop(-1, -1);
      sweep("final_store");

      // Start held high: one run per IDLE entry with one IDLE cycle between
      mk    = KEY1;
      start = 1'b1;
      tick();
      chk("held_busy_a", 32'(busy), 32'd1);
      chk("held_valid_a", 32'(rk_valid), 32'd0);
      run_loop(-1, -1);
      chk("held_idle_gap", 32'(busy), 32'd0);
      tick();
      chk("held_busy_b", 32'(busy), 32'd1);
      chk("held_valid_b", 32'(rk_valid), 32'd0);
      chk("held_key_ready_b", 32'(key_ready), 32'd0);
      run_loop(-1, -1);
      start = 1'b0;
      tick();
      chk("held_end_busy", 32'(busy), 32'd0);
      chk("held_end_valid", 32'(rk_valid), 32'd0);
      tick();
      chk("held_end_busy2", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sm4_key_schedule.md
Name: sm4_key_schedule

Overview:
- Sequential SM4 key-expansion controller that sits directly upstream of, and wraps, the combinational key-round function Frk_function.
- Loads the 128-bit master key and applies FK. It then iterates 32 rounds, one per clock, generating CK on the fly and feeding each round result back as the next round's input.
- Streams each round key rk[i] to the cipher datapath and keeps all 32 in a key store. The encrypt/decrypt datapath reads the store by index; decryption reads index 31-i.

Parameters:
- NROUNDS, 32, number of key rounds. Fixed by SM4; only 32 is supported.
- CK_STEP, 28, per-round increment of every CK byte, modulo 256.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to expand mk. Honoured only in IDLE.
- mk  input  [0:127]  master key; mk[0:31] is MK0 … mk[96:127] is MK3. Sampled in the cycle start is accepted.
- busy  output  1  high while in RUN
- rk_valid  output  1  registered; high for one cycle per produced round key
- rk_out  output  [0:31]  registered round key
- rk_idx  output  [4:0]  round number of rk_out, 0..31
- done  output  1  one-cycle pulse coincident with rk_idx=31
- key_ready  output  1  store holds a complete, consistent schedule
- rk_rd_idx  input  [4:0]  key-store read address
- rk_rd_data  output  [0:31]  combinational read: store[rk_rd_idx]

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; K0..K3, ck register, round counter, rk_out, rk_idx and store all cleared to 0.
  - busy, rk_valid, done and key_ready all 0.
  - Reset mid-RUN aborts the run; no partial schedule survives.
- States: IDLE, RUN.
- IDLE, start=1 at edge T:
  - K0..K3 <= MK0^A3B1BAC6, MK1^56AA3350, MK2^677D9197, MK3^B27022DC.
  - ck <= 00070E15; round <= 0; key_ready <= 0; state <= RUN.
- RUN, each cycle with round=r:
  - rk = Frk(K0,K1,K2,K3,ck) = K0 ^ T'(K1^K2^K3^ck), computed by the Frk_function instance.
  - At the edge: store[r] <= rk; rk_out <= rk; rk_idx <= r; rk_valid <= 1.
  - Shift: K0 <= K1, K1 <= K2, K2 <= K3, K3 <= rk.
  - Each ck byte <= byte+28 mod 256, byte-wise with no carry between bytes. CK[i] byte j = (4i+j)*7 mod 256.
  - round <= r+1, 5-bit.
- r=31 edge:
  - done <= 1; key_ready <= 1; state <= IDLE.
  - The round counter wraps to 0 and is not reused.
- Timing:
  - busy is high for exactly 32 cycles (edges T+1..T+32).
  - rk_valid is high for 32 consecutive cycles after edges T+1..T+32, with rk_idx 0..31.
  - done and key_ready rise after edge T+32, i.e. 33 edges after start.
- rk_valid and done deassert the cycle after their last assertion. No backpressure: consumers must accept every rk_valid cycle.
- start while busy=1 is ignored; mk changes during RUN have no effect.
- start in the same cycle as the final round (r=31) is ignored; start is accepted from the next IDLE cycle.
- A new accepted start clears key_ready immediately. The store is overwritten progressively, so a reader must gate on key_ready.
- rk_rd_data is valid whenever key_ready=1. When key_ready=0 it returns current store contents, with no guarantee of consistency.
- The read port never stalls key generation; reading and writing the same index in one cycle returns the old value.

Decomposition:
- Shared package sm4_pkg holds:
  - FK0..FK3 constants and the CK0 seed 00070E15;
  - CK_STEP and NROUNDS;
  - the state encoding (IDLE=0, RUN=1);
  - 32-bit word and 5-bit round-index types.
- Sub-module: instantiate the existing combinational Frk_function, which contains Trk_synchange, for the round datapath. No new sub-module is required.
- The key store is a 32x32 flop array local to this block.

Test Plan:
- mk=0123456789ABCDEFFEDCBA9876543210, start pulse:
  - busy high 32 cycles; rk_idx 0 gives F12186F9, idx 1 gives 41662B61, idx 31 gives 9124A012;
  - done on idx 31, then key_ready=1.
- After that run, sweep rk_rd_idx 0..31: rk_rd_data matches the streamed rk_out per index (idx 31 reads 9124A012). Check CK seen internally at round 31 is 646B7279.
- During RUN at round 10, pulse start with mk=all-ones: ignored, output sequence identical to scenario 1.
- Deassert rst_n at round 15: all outputs 0 immediately, key_ready=0. A fresh start then reproduces the scenario 1 sequence from idx 0.
- Back-to-back runs: start mk=0 right after done, then mk=scenario 1 key:
  - key_ready drops on acceptance;
  - each run gives 32 rk_valid cycles;
  - the final store matches the scenario 1 vector.
- start held high continuously: exactly one run per IDLE entry. Each run is 32 valid keys, followed by one IDLE cycle before the next busy.
